// File: rtl/dm_pkg.sv
// ============================================================================
// Module   : dm_pkg
// Brief    : Shared debug-module bus definitions (arbiter states, timeout).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dm_state_e;

  localparam int DM_TIMEOUT = 255;

endpackage

`default_nettype wire

// File: rtl/dm_rr_pick.sv
// ============================================================================
// Module   : dm_rr_pick
// Brief    : Combinational two-way grant decision, round-robin or fixed m0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_rr_pick
  import dm_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last,
  input  logic i_rr_en,
  output logic o_winner
);

  always_comb begin
    o_winner = 1'b0;
    if (i_valid0 && i_valid1) begin
      o_winner = i_rr_en ? ~i_last : 1'b0;
    end else if (i_valid1) begin
      o_winner = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dm_bus_arbiter.sv
// ============================================================================
// Module   : dm_bus_arbiter
// Brief    : Arbitrates fetch (m0) and load/store (m1) onto one DM bus port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_bus_arbiter
  import dm_pkg::*;
#(
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = DM_TIMEOUT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_write,
  input  logic [19:2] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_write,
  input  logic [19:2] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic        s_write,
  output logic [19:2] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        err
);

  localparam int                 c_cnt_w   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
  localparam logic               c_rr_en   = (RR_EN != 0);

  dm_state_e          r_state;
  dm_state_e          w_state_nxt;
  logic               r_owner;
  logic               r_last;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_winner;
  logic               w_own_valid;
  logic               w_cmpl;
  logic [31:0]        w_rdata;

  dm_rr_pick u_pick (
    .i_valid0 (m0_valid),
    .i_valid1 (m1_valid),
    .i_last   (r_last),
    .i_rr_en  (c_rr_en),
    .o_winner (w_winner)
  );

  assign w_own_valid = r_owner ? m1_valid : m0_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_cmpl      = 1'b0;
    w_rdata     = 32'h0;
    s_valid     = 1'b0;
    s_write     = 1'b0;
    s_addr      = '0;
    s_wdata     = 32'h0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = 32'h0;
    m1_rdata    = 32'h0;
    err         = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_valid = w_own_valid;
        s_write = r_owner ? m1_write : m0_write;
        s_addr  = r_owner ? m1_addr  : m0_addr;
        s_wdata = r_owner ? m1_wdata : m0_wdata;
        if (!w_own_valid) begin
          w_state_nxt = IDLE;
        end else if (s_ready || (r_cnt == c_timeout)) begin
          // A real slave response beats a timeout landing in the same cycle
          w_state_nxt = IDLE;
          w_cmpl      = 1'b1;
          w_rdata     = s_ready ? s_rdata : 32'h0;
          err         = ~s_ready;
          if (r_owner) begin
            m1_ready = 1'b1;
            m1_rdata = w_rdata;
          end else begin
            m0_ready = 1'b1;
            m0_rdata = w_rdata;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && (m0_valid || m1_valid)) begin
        r_owner <= w_winner;
        r_cnt   <= '0;
      end else if ((r_state == BUSY) && !s_ready) begin
        r_cnt <= r_cnt + c_one;
      end
      if (w_cmpl) begin
        r_last <= r_owner;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_bus_arbiter.sv
// ============================================================================
// Module   : tb_dm_bus_arbiter
// Brief    : Scoreboard bench for dm_bus_arbiter (RR/TIMEOUT=4 and fixed-priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_bus_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Requester inputs indexed [instance][master]; instance 0 = A, 1 = B
  logic        mv  [2][2];
  logic        mw  [2][2];
  logic [19:2] ma  [2][2];
  logic [31:0] mwd [2][2];

  logic        a_m0_ready, a_m1_ready, a_s_valid, a_s_ready, a_s_write, a_err;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_wdata, a_s_rdata;
  logic [19:2] a_s_addr;
  logic        b_m0_ready, b_m1_ready, b_s_valid, b_s_ready, b_s_write, b_err;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_wdata, b_s_rdata;
  logic [19:2] b_s_addr;
  logic        stall_a = 1'b0;

  dm_bus_arbiter #(.RR_EN(1), .TIMEOUT(4)) u_dut_a (
    .clk(clk), .resetn(resetn),
    .m0_valid(mv[0][0]), .m0_ready(a_m0_ready), .m0_write(mw[0][0]),
    .m0_addr(ma[0][0]), .m0_wdata(mwd[0][0]), .m0_rdata(a_m0_rdata),
    .m1_valid(mv[0][1]), .m1_ready(a_m1_ready), .m1_write(mw[0][1]),
    .m1_addr(ma[0][1]), .m1_wdata(mwd[0][1]), .m1_rdata(a_m1_rdata),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_write(a_s_write),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_rdata(a_s_rdata),
    .err(a_err)
  );

  dm_bus_arbiter #(.RR_EN(0)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .m0_valid(mv[1][0]), .m0_ready(b_m0_ready), .m0_write(mw[1][0]),
    .m0_addr(ma[1][0]), .m0_wdata(mwd[1][0]), .m0_rdata(b_m0_rdata),
    .m1_valid(mv[1][1]), .m1_ready(b_m1_ready), .m1_write(mw[1][1]),
    .m1_addr(ma[1][1]), .m1_wdata(mwd[1][1]), .m1_rdata(b_m1_rdata),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_write(b_s_write),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rdata(b_s_rdata),
    .err(b_err)
  );

  // Debug-module slave: word 0 holds a NOP, ready one cycle after valid
  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h0000_0013 : (32'h1000_0000 + 32'(i));
  endfunction

  logic [31:0] mem_a [0:15];
  logic [31:0] mem_b [0:15];

  always @(posedge clk) begin
    if (!resetn) begin
      a_s_ready <= 1'b0;
      for (int i = 0; i < 16; i++) mem_a[i] <= init_word(i);
    end else begin
      a_s_ready <= a_s_valid && !a_s_ready && !stall_a;
      if (a_s_valid && a_s_ready && a_s_write) mem_a[a_s_addr[5:2]] <= a_s_wdata;
    end
  end
  assign a_s_rdata = mem_a[a_s_addr[5:2]];

  always @(posedge clk) begin
    if (!resetn) begin
      b_s_ready <= 1'b0;
      for (int i = 0; i < 16; i++) mem_b[i] <= init_word(i);
    end else begin
      b_s_ready <= b_s_valid && !b_s_ready;
      if (b_s_valid && b_s_ready && b_s_write) mem_b[b_s_addr[5:2]] <= b_s_wdata;
    end
  end
  assign b_s_rdata = mem_b[b_s_addr[5:2]];

  int   cyc   = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= !resetn;
  end

  typedef struct {
    int          k;
    int          m;
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_done [2];
  bit   end_req = 1'b0;
  bit   mon_done = 1'b0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %h, required %h", name, k, cyc, act, req);
    end
  endtask

  task automatic exp_push(input int k, input int m, input logic [31:0] rd, input logic er, input int c);
    exp_t e;
    e.k = k; e.m = m; e.rd = rd; e.er = er; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic mon_inst(input int k, input logic r0, input logic r1, input logic [31:0] d0,
                          input logic [31:0] d1, input logic e, input logic sv);
    int   idx;
    logic exp_now;
    if (rst_q) begin
      chk("reset_idle", k, 32'({sv, r0, r1, e}), 32'h0);
      prev_done[k] = 1'b0;
      return;
    end
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (idx < 0 && exp_q[i].k == k) idx = i;
    end
    exp_now = (idx >= 0) && (exp_q[idx].cyc == cyc);
    if (prev_done[k]) chk("idle_after_done", k, 32'(sv), 32'h0);
    chk("ready_when", k, 32'(r0 | r1), 32'(exp_now));
    if (!r0) chk("m0_rdata_zero", k, d0, 32'h0);
    if (!r1) chk("m1_rdata_zero", k, d1, 32'h0);
    if (exp_now) begin
      chk("grant_m0", k, 32'(r0), 32'(exp_q[idx].m == 0));
      chk("grant_m1", k, 32'(r1), 32'(exp_q[idx].m == 1));
      chk("rdata", k, r1 ? d1 : d0, exp_q[idx].rd);
      chk("err", k, 32'(e), 32'(exp_q[idx].er));
      exp_q.delete(idx);
    end else begin
      chk("err_quiet", k, 32'(e), 32'h0);
    end
    prev_done[k] = exp_now && (r0 | r1);
  endtask

  initial begin
    prev_done[0] = 1'b0;
    prev_done[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        mon_inst(0, a_m0_ready, a_m1_ready, a_m0_rdata, a_m1_rdata, a_err, a_s_valid);
        mon_inst(1, b_m0_ready, b_m1_ready, b_m0_rdata, b_m1_rdata, b_err, b_s_valid);
      end
      if (end_req && !mon_done) begin
        chk("pending_at_end", 0, 32'(exp_q.size()), 32'h0);
        mon_done = 1'b1;
      end
    end
  end

  function automatic logic rdy(input int k, input int j);
    case ({k[0], j[0]})
      2'b00:   return a_m0_ready;
      2'b01:   return a_m1_ready;
      2'b10:   return b_m0_ready;
      default: return b_m1_ready;
    endcase
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until ready (bounded), then release
  task automatic do_req(input int k, input int j, input logic wr, input logic [19:2] a, input logic [31:0] wd);
    mv[k][j] = 1'b1; mw[k][j] = wr; ma[k][j] = a; mwd[k][j] = wd;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy(k, j)) break;
    end
    sync();
    mv[k][j] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        mv[k][j] = 1'b0; mw[k][j] = 1'b0; ma[k][j] = '0; mwd[k][j] = 32'h0;
      end
    end
    resetn = 1'b0;
    repeat (3) sync();
    resetn = 1'b1;
    sync();

    // Continuous requests from both masters: A alternates, B favours m0
    c0 = cyc;
    exp_push(0, 0, 32'h0000_0013, 1'b0, c0 + 2);
    exp_push(0, 1, 32'h1000_0003, 1'b0, c0 + 5);
    exp_push(0, 0, 32'h1000_0002, 1'b0, c0 + 8);
    exp_push(0, 1, 32'h1000_0005, 1'b0, c0 + 11);
    exp_push(1, 0, 32'h0000_0013, 1'b0, c0 + 2);
    exp_push(1, 0, 32'h1000_0002, 1'b0, c0 + 5);
    exp_push(1, 1, 32'h1000_0003, 1'b0, c0 + 8);
    exp_push(1, 1, 32'h1000_0005, 1'b0, c0 + 11);
    fork
      begin do_req(0, 0, 1'b0, 18'd0, 32'h0); do_req(0, 0, 1'b0, 18'd2, 32'h0); end
      begin do_req(0, 1, 1'b0, 18'd3, 32'h0); do_req(0, 1, 1'b0, 18'd5, 32'h0); end
      begin do_req(1, 0, 1'b0, 18'd0, 32'h0); do_req(1, 0, 1'b0, 18'd2, 32'h0); end
      begin do_req(1, 1, 1'b0, 18'd3, 32'h0); do_req(1, 1, 1'b0, 18'd5, 32'h0); end
    join
    repeat (2) sync();

    // Single m0 fetch of the NOP at address 0
    c0 = cyc;
    exp_push(0, 0, 32'h0000_0013, 1'b0, c0 + 2);
    do_req(0, 0, 1'b0, 18'd0, 32'h0);
    sync();

    // m1 store then m0 load of the same word
    c0 = cyc;
    exp_push(0, 1, 32'h1000_0001, 1'b0, c0 + 2);
    exp_push(0, 0, 32'hDEAD_BEEF, 1'b0, c0 + 5);
    do_req(0, 1, 1'b1, 18'd1, 32'hDEAD_BEEF);
    do_req(0, 0, 1'b0, 18'd1, 32'h0);
    sync();

    // Slave never answers: error completion after 4 counted BUSY cycles
    stall_a = 1'b1;
    c0 = cyc;
    exp_push(0, 0, 32'h0, 1'b1, c0 + 5);
    do_req(0, 0, 1'b0, 18'd2, 32'h0);
    stall_a = 1'b0;
    sync();

    // Slave answers exactly on the timeout cycle: normal completion wins
    c0 = cyc;
    exp_push(0, 0, 32'h1000_0002, 1'b0, c0 + 5);
    fork
      do_req(0, 0, 1'b0, 18'd2, 32'h0);
      begin stall_a = 1'b1; repeat (4) sync(); stall_a = 1'b0; end
    join
    sync();

    // Reset while m1 owns the bus, then a tie must go to m0
    mv[0][1] = 1'b1; mw[0][1] = 1'b0; ma[0][1] = 18'd3;
    sync();
    resetn = 1'b0;
    mv[0][1] = 1'b0;
    repeat (2) sync();
    resetn = 1'b1;
    c0 = cyc;
    exp_push(0, 0, 32'h0000_0013, 1'b0, c0 + 2);
    exp_push(0, 1, 32'h1000_0003, 1'b0, c0 + 5);
    fork
      do_req(0, 0, 1'b0, 18'd0, 32'h0);
      do_req(0, 1, 1'b0, 18'd3, 32'h0);
    join
    repeat (3) sync();

    end_req = 1'b1;
    for (int n = 0; n < 20 && !mon_done; n++) @(posedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_stalled: end-of-test check never ran");
      $fatal(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_bus_arbiter.md
DM_BUS_ARBITER -- requirements
Module: dm_bus_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin and 0 = fixed priority with m0 highest.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the number of BUSY cycles without s_ready before an error completion.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have ports m0_valid (in, 1), m0_ready (out, 1), m0_write (in, 1), m0_addr (in, [19:2]), m0_wdata (in, 32) and m0_rdata (out, 32): the instruction-fetch requester.
REQ-006 SHALL have ports m1_valid, m1_ready, m1_write, m1_addr, m1_wdata and m1_rdata, with the same directions and widths: the load/store requester.
REQ-007 SHALL have ports s_valid (out, 1), s_ready (in, 1), s_write (out, 1), s_addr (out, [19:2]), s_wdata (out, 32) and s_rdata (in, 32): the single debug-module bus port.
REQ-008 SHALL have port err (out, 1): a one-cycle pulse on a timeout completion.

Function
REQ-009 SHALL implement the states IDLE and BUSY, plus a registered owner bit and a registered last-grant bit.
REQ-010 In IDLE, SHALL hold s_valid=0 and both mN_ready=0.
REQ-011 In IDLE with any mN_valid=1, SHALL latch the owner and enter BUSY on the next cycle, giving 1 cycle of arbitration latency.
REQ-012 Arbitration with RR_EN=1 and both valid SHALL grant the master that is not last-grant.
REQ-013 Arbitration with RR_EN=0 and both valid SHALL grant m0.
REQ-014 Arbitration with a single valid master SHALL grant that master.
REQ-015 In BUSY, SHALL drive s_valid, s_write, s_addr and s_wdata combinationally from the owner's inputs.
REQ-016 In BUSY, SHALL hold the non-owner's ready at 0.
REQ-017 On s_valid && s_ready in BUSY, SHALL assert owner mN_ready=1 in the same cycle with mN_rdata=s_rdata, update last-grant to the owner, and return to IDLE.
REQ-018 SHALL drive mN_rdata to 0 whenever mN_ready=0.
REQ-019 The mandatory IDLE cycle after every completion SHALL deassert s_valid so that the slave's ready toggles back to 0; back-to-back transactions from one master therefore complete at most once every 3 cycles.
REQ-020 Requesters SHALL hold valid, write, addr and wdata stable until ready.
REQ-021 If the owner drops valid in BUSY, the block SHALL return to IDLE on the next cycle without asserting ready.
REQ-022 The timeout counter SHALL be 8 bits (sized to TIMEOUT), cleared on entry to BUSY, and SHALL increment each BUSY cycle that has no s_ready.
REQ-023 When the counter equals TIMEOUT, SHALL assert owner ready=1 with rdata=32'h0 and err=1 for that one cycle, then return to IDLE.
REQ-024 If s_ready arrives in the same cycle as the timeout, the normal completion SHALL win and err SHALL stay 0.
REQ-025 A new valid arriving during BUSY SHALL wait; it SHALL never preempt the owner.
REQ-026 The arbiter SHALL be starvation-free with RR_EN=1: under continuous requests grants alternate m0, m1, m0, and so on.

Reset
REQ-027 While resetn=0, the block SHALL be in IDLE with owner=0, last-grant=1 (so m0 wins the first tie), counter=0, err=0, s_valid=0, m0_ready=0 and m1_ready=0.
REQ-028 Reset asserted mid-BUSY SHALL abandon the transaction with no ready pulse, and outputs SHALL reach reset values on the next edge.

Structure
REQ-029 The state encoding (IDLE=1'b0, BUSY=1'b1) and the default TIMEOUT constant SHALL reside in the shared debug package dm_pkg.
REQ-030 The grant decision SHALL be one sub-module, dm_rr_pick (inputs: two valids, last-grant and RR_EN; output: winner), which is purely combinational.
REQ-031 The remainder SHALL be a single module.

Verification
REQ-032 The bench SHALL cover: m0 read of addr 0x0 from a debug module at reset contents -> s_valid in cycle 1, m0_ready in cycle 2, m0_rdata=32'h00000013.
REQ-033 The bench SHALL cover: m0 and m1 both asserting valid continuously with RR_EN=1 -> grants m0, m1, m0, m1, with each completion followed by one IDLE cycle.
REQ-034 The bench SHALL cover: the same stimulus with RR_EN=0 -> m0 wins every tie, and m1 is granted only while m0_valid=0.
REQ-035 The bench SHALL cover: m1 write of 32'hDEADBEEF to addr 0x4 followed by an m0 read of addr 0x4 -> m0_rdata=32'hDEADBEEF.
REQ-036 The bench SHALL cover: s_ready tied to 0 with TIMEOUT=4 -> ready and a one-cycle err=1 after 4 BUSY cycles, rdata=0, then IDLE.
REQ-037 The bench SHALL cover: resetn=0 in the middle of BUSY -> no ready pulse, s_valid=0 on the next edge, and the first tie after reset goes to m0.
